vc_deserializer: RTL and testbench

- Sits directly downstream of the 4:1 VC mux and the weighted round-robin arbiter.
- Consumes the serial bit on data_out together with the granted VC_id, one bit per clock.
- Rebuilds one parallel word per virtual channel in independent per-VC shift registers.
- Presents each completed word on a single-entry valid/ready output register, tagged with its VC.

---
 rtl/vc_deserializer.sv | 79 +++++++
 tb/tb_vc_deserializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vc_deserializer.sv
// Per-VC serial-to-parallel reassembly behind the VC mux / arbiter.
// Completed words go to a single-entry valid/ready output register tagged with their VC.
module vc_deserializer #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        vc_id,
    input  logic              data_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [1:0]        out_vc,
    output logic [WORD_W-1:0] out_word,
    output logic              overflow,
    output logic [3:0]        busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    // Only the low WORD_W-1 bits are kept; the incoming bit completes the word.
    logic [WORD_W-2:0] sr  [4];
    logic [CNT_W-1:0]  cnt [4];

    logic [WORD_W-1:0] shifted;
    logic              word_done;
    logic              load;

    always_comb begin
        shifted   = {sr[vc_id], data_in};
        word_done = in_valid && (cnt[vc_id] == LAST);
        load      = word_done && (!out_valid || out_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                sr[i]  <= '0;
                cnt[i] <= '0;
            end
        end else if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (vc_id == 2'(i)) begin
                    sr[i]  <= shifted[WORD_W-2:0];
                    cnt[i] <= (cnt[i] == LAST) ? '0 : cnt[i] + 1'b1;
                end
            end
        end
    end

    // A completion that finds the register full and not draining is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_vc    <= 2'd0;
            out_word  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_vc    <= vc_id;
                out_word  <= shifted;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (word_done && out_valid && !out_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            busy[i] = (cnt[i] != '0);
        end
    end

endmodule

// File: tb/tb_vc_deserializer.sv
// Scoreboard bench for vc_deserializer: a per-VC bit-accumulation model predicts words,
// drops and busy flags; a negedge monitor compares against the DUT.
module tb_vc_deserializer;

    localparam int WORD_W = 8;

    typedef struct packed {
        logic [1:0]        vc;
        logic [WORD_W-1:0] word;
    } item_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [1:0]        vc_id;
    logic              data_in;
    logic              out_ready;
    logic              out_valid;
    logic [1:0]        out_vc;
    logic [WORD_W-1:0] out_word;
    logic              overflow;
    logic [3:0]        busy;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: bits seen so far per VC, value as an integer, plus the output slot.
    int                acc_cnt [4];
    int                acc_val [4];
    item_t             exp_q [$];
    logic              m_valid;
    logic [1:0]        m_vc;
    logic [WORD_W-1:0] m_word;
    logic              m_ovf;

    always #5 clk = ~clk;

    vc_deserializer #(.WORD_W(WORD_W), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .vc_id     (vc_id),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_vc    (out_vc),
        .out_word  (out_word),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            acc_cnt[i] = 0;
            acc_val[i] = 0;
        end
        exp_q.delete();
        m_valid = 1'b0;
        m_vc    = 2'd0;
        m_word  = '0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] vc, input logic b, input logic rdy);
        logic              done;
        logic [WORD_W-1:0] word;
        done = 1'b0;
        word = '0;
        if (v) begin
            acc_val[vc] = acc_val[vc] * 2 + int'(b);
            acc_cnt[vc] = acc_cnt[vc] + 1;
            if (acc_cnt[vc] == WORD_W) begin
                done        = 1'b1;
                word        = WORD_W'(acc_val[vc]);
                acc_cnt[vc] = 0;
                acc_val[vc] = 0;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_vc    = vc;
                m_word  = word;
                exp_q.push_back('{vc: vc, word: word});
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    function automatic logic [3:0] exp_busy();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (acc_cnt[i] != 0);
        return r;
    endfunction

    task automatic applyStimulus(input logic v, input logic [1:0] vc, input logic b, input logic rdy);
        in_valid  = v;
        vc_id     = vc;
        data_in   = b;
        out_ready = rdy;
        @(posedge clk);
        model_edge(v, vc, b, rdy);
        #1;
    endtask

    task automatic send_word(input logic [1:0] vc, input logic [WORD_W-1:0] w,
                             input logic rdy, input bit gaps);
        for (int i = WORD_W - 1; i >= 0; i--) begin
            applyStimulus(1'b1, vc, w[i], rdy);
            if (gaps) applyStimulus(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rdy);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 1'b0, rdy);
    endtask

    // Monitor: per-cycle state checks plus scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (reset) begin
            item_t e;
            checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("busy", 32'(busy), 32'(exp_busy()));
            if (m_valid) checkOutput("held_word", 32'({out_vc, out_word}), 32'({m_vc, m_word}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", 32'({out_vc, out_word}), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("accepted_word", 32'({out_vc, out_word}), 32'({e.vc, e.word}));
                end
            end
        end
    end

    initial begin
        logic [WORD_W-1:0] w0, w1;
        reset     = 1'b0;
        in_valid  = 1'b1;
        vc_id     = 2'd0;
        data_in   = 1'b1;
        out_ready = 1'b0;
        model_reset();
        #12;
        checkOutput("reset_outputs", 32'({out_valid, out_vc, out_word, overflow, busy}), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;

        // VC2 carries 8'hB2; visible one cycle after the last bit, then drained.
        send_word(2'd2, 8'hB2, 1'b1, 1'b0);
        checkOutput("t1_word", 32'({out_valid, out_vc, out_word}), 32'({1'b1, 2'd2, 8'hB2}));
        idle(1, 1'b1);
        checkOutput("t1_drop_valid", 32'(out_valid), 32'd0);
        idle(1, 1'b1);

        // Interleave VC0 = A5 and VC1 = 3C bit by bit.
        w0 = 8'hA5;
        w1 = 8'h3C;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            applyStimulus(1'b1, 2'd0, w0[i], 1'b1);
            applyStimulus(1'b1, 2'd1, w1[i], 1'b1);
        end
        checkOutput("t2_second", 32'({out_vc, out_word}), 32'({2'd1, 8'h3C}));
        idle(2, 1'b1);

        // Completion in the same cycle the previous word is taken.
        w1 = 8'h6E;
        for (int i = WORD_W - 1; i >= 1; i--) applyStimulus(1'b1, 2'd1, w1[i], 1'b1);
        send_word(2'd0, 8'h33, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd1, w1[0], 1'b1);
        checkOutput("t4_back_to_back", 32'({out_valid, out_vc, out_word, overflow}),
                    32'({1'b1, 2'd1, 8'h6E, 1'b0}));
        idle(2, 1'b1);

        // Stalled output: second word is dropped and overflow sticks.
        send_word(2'd3, 8'hFF, 1'b0, 1'b0);
        send_word(2'd0, 8'h01, 1'b0, 1'b0);
        checkOutput("t3_held", 32'({out_vc, out_word, overflow}), 32'({2'd3, 8'hFF, 1'b1}));
        idle(1, 1'b1);
        checkOutput("t3_drained", 32'(out_valid), 32'd0);
        idle(3, 1'b1);

        // Partial word on VC1 survives idle cycles, then an async reset discards it.
        w1 = 8'hC0;
        for (int i = WORD_W - 1; i >= 4; i--) applyStimulus(1'b1, 2'd1, w1[i], 1'b1);
        idle(3, 1'b1);
        checkOutput("t5_busy_hold", 32'(busy), 32'b0010);
        send_word(2'd2, 8'h77, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("t5_async_reset", 32'({busy, out_valid, out_word, overflow}), 32'd0);
        #1;
        reset = 1'b1;
        model_reset();
        send_word(2'd1, 8'h5A, 1'b1, 1'b0);
        checkOutput("t5_new_word", 32'({out_vc, out_word}), 32'({2'd1, 8'h5A}));
        idle(2, 1'b1);

        // VC0 word with idle gaps between every bit.
        send_word(2'd0, 8'h80, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end
        idle(4, 1'b1);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
